retire_release_buffer: RTL and testbench
========================================

RETIRE_RELEASE_BUFFER -- requirements
Module: RetireReleaseBuffer

Interface
REQ-001 Parameter SIZE_PHYSICAL_LOG, default `SIZE_PHYSICAL_LOG, width of a physical register tag.
REQ-002 Parameter DEPTH, default 16, number of buffer entries, power of two, >= 8.
REQ-003 Parameter DEPTH_LOG, default 4, log2(DEPTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 retireValid0_i..retireValid3_i  input  1 each  retiring instruction in slot k frees its old physical mapping.
REQ-007 retireReg0_i..retireReg3_i  input  SIZE_PHYSICAL_LOG each  old physical register tag for slot k; ignored when retireValid k is 0.
REQ-008 holdRelease_i  input  1  free-list back-pressure; while 1, no entries are drained.
REQ-009 retireReady_o  input-side ready  output  1  buffer can accept 4 entries this cycle.
REQ-010 commitValid0_o..commitValid3_o  output  1 each  release slot k carries a freed tag; feeds the free list's commitValid k.
REQ-011 commitReg0_o..commitReg3_o  output  SIZE_PHYSICAL_LOG each  freed tag for slot k.
REQ-012 count_o  output  DEPTH_LOG+1  current occupancy.
REQ-013 overflowErr_o  output  1  sticky error: retire offered while not ready.

Function
REQ-014 Buffer is a circular FIFO with head, tail (DEPTH_LOG bits, wrap modulo DEPTH) and count (DEPTH_LOG+1 bits, 0..DEPTH).
REQ-015 retireReady_o = (DEPTH - count >= 4), combinational from registered count only.
REQ-016 Push: when retireReady_o=1, valid retire slots are written in ascending slot order to tail, tail+1, ... (gaps compacted); m = number of valid slots (0..4).
REQ-017 When retireReady_o=0 and any retireValid k=1, inputs are dropped, m=0, overflowErr_o set to 1 and held until reset.
REQ-018 Pop: n = 0 if holdRelease_i=1, else min(count, 4), count being the pre-edge value; entries pushed this edge are not poppable this edge.
REQ-019 commit outputs are registered: at each edge, slots 0..n-1 load valid=1 and the head..head+n-1 tags in FIFO order; slots n..3 load valid=0, tag=0.
REQ-020 Released outputs are always packed: commitValid k=1 implies commitValid j=1 for all j<k.
REQ-021 Latency: tag retired at edge E appears on commit outputs no earlier than after edge E+1 (2 edges retire-to-release when not held).
REQ-022 Next state: head += n, tail += m (mod DEPTH), count = count - n + m; simultaneous push and pop in one edge is supported at every occupancy.
REQ-023 holdRelease_i=1 forces all commitValid outputs to 0 after the edge; pushes continue per REQ-016.
REQ-024 Ordering: tags are released in exactly the order pushed (slot order within a cycle, cycle order across cycles); no tag duplicated or lost.
REQ-025 Wrap-around: writes and reads spanning index DEPTH-1 to 0 in one cycle are handled without bubble.
REQ-026 Full (count=DEPTH) and empty (count=0) are both legal; empty yields all commitValid=0 next edge.

Reset
REQ-027 On reset: head=0, tail=0, count=0, overflowErr_o=0, all commitValid k=0, all commitReg k=0; retireReady_o=1 after reset.
REQ-028 Reset mid-operation discards all buffered entries and any pending push/pop at that edge; reset has priority over all other inputs.

Verification
REQ-029 After reset, retireValid=1111 tags 5,6,7,8 with hold=0 -> next edge count=4, outputs invalid; following edge commitValid=1111, commitReg=5,6,7,8, count=0.
REQ-030 retireValid=1010 tags (x,9,x,12) -> two edges later commitValid=1100, commitReg0=9, commitReg1=12.
REQ-031 hold=1 for 4 cycles with 4 retires/cycle -> count=16, retireReady_o=0, commitValid=0000; 5th cycle retire offered -> overflowErr_o=1, count stays 16.
REQ-032 Head at 14, count=6, hold dropped -> releases entries 14,15,0,1 in order, head=2, count=2 plus any pushes.
REQ-033 Steady push 3/cycle, pop 4/cycle from count=5 -> count sequence 5,4,3,3,...; all tags released in push order.
REQ-034 Reset asserted with count=7 and valid outputs -> next edge count=0, commitValid=0000, overflowErr_o=0.

Source files
------------

// File: rtl/retire_release_buffer.sv
// Retire-to-release staging FIFO: compacts up to 4 retired old-physical tags per cycle and drains up to 4 per cycle to the free list.
// Latency: a tag pushed at edge E is visible on the registered commit outputs after edge E+1 at the earliest.
// Backpressure: retireReady_o drops when fewer than 4 entries are free; holdRelease_i stalls draining; retires offered while not ready are dropped and flagged.
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

module retire_release_buffer #(
  parameter int SIZE_PHYSICAL_LOG = `SIZE_PHYSICAL_LOG,
  parameter int DEPTH             = 16,
  parameter int DEPTH_LOG         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         retireValid0_i,
  input  logic                         retireValid1_i,
  input  logic                         retireValid2_i,
  input  logic                         retireValid3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] retireReg0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] retireReg1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] retireReg2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] retireReg3_i,
  input  logic                         holdRelease_i,
  output logic                         retireReady_o,
  output logic                         commitValid0_o,
  output logic                         commitValid1_o,
  output logic                         commitValid2_o,
  output logic                         commitValid3_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] commitReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] commitReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] commitReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] commitReg3_o,
  output logic [DEPTH_LOG:0]           count_o,
  output logic                         overflowErr_o
);

  logic [3:0]                   rv;
  logic [SIZE_PHYSICAL_LOG-1:0] rr [4];

  logic [SIZE_PHYSICAL_LOG-1:0] mem [DEPTH];
  logic [DEPTH_LOG-1:0]         head;
  logic [DEPTH_LOG-1:0]         tail;
  logic [DEPTH_LOG:0]           count;
  logic                         overflow_err;

  logic                         ready;
  logic [2:0]                   off1, off2, off3;
  logic [2:0]                   push_num;
  logic [2:0]                   pop_num;
  logic [DEPTH_LOG-1:0]         wr_idx [4];
  logic [DEPTH_LOG-1:0]         rd_idx [4];

  logic                         cv [4];
  logic [SIZE_PHYSICAL_LOG-1:0] cr [4];

  assign rv    = {retireValid3_i, retireValid2_i, retireValid1_i, retireValid0_i};
  assign rr[0] = retireReg0_i;
  assign rr[1] = retireReg1_i;
  assign rr[2] = retireReg2_i;
  assign rr[3] = retireReg3_i;

  // Ready depends only on the registered occupancy so it never loops back through the retire inputs.
  assign ready = (count <= (DEPTH_LOG+1)'(DEPTH - 4));

  // Slot k lands at tail + (number of valid slots below k), which packs out gaps.
  always_comb begin
    off1     = {2'b00, rv[0]};
    off2     = off1 + {2'b00, rv[1]};
    off3     = off2 + {2'b00, rv[2]};
    push_num = ready ? (off3 + {2'b00, rv[3]}) : 3'd0;
    if (holdRelease_i) begin
      pop_num = 3'd0;
    end else if (count >= (DEPTH_LOG+1)'(4)) begin
      pop_num = 3'd4;
    end else begin
      pop_num = count[2:0];
    end
    wr_idx[0] = tail;
    wr_idx[1] = tail + DEPTH_LOG'(off1);
    wr_idx[2] = tail + DEPTH_LOG'(off2);
    wr_idx[3] = tail + DEPTH_LOG'(off3);
    for (int k = 0; k < 4; k++) begin
      rd_idx[k] = head + DEPTH_LOG'(k);
    end
  end

  // Storage array; only written when the whole 4-entry burst is guaranteed to fit.
  always_ff @(posedge clk) begin
    if (!reset && ready) begin
      for (int k = 0; k < 4; k++) begin
        if (rv[k]) begin
          mem[wr_idx[k]] <= rr[k];
        end
      end
    end
  end

  // Pointer and occupancy update; push and pop resolve in the same edge at any occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + DEPTH_LOG'(pop_num);
      tail  <= tail + DEPTH_LOG'(push_num);
      count <= count - (DEPTH_LOG+1)'(pop_num) + (DEPTH_LOG+1)'(push_num);
    end
  end

  // Sticky overflow flag: a retire offered while not ready is lost, so it is latched until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (!ready && (|rv)) begin
      overflow_err <= 1'b1;
    end
  end

  // Registered release slots, always packed from slot 0, read from pre-edge storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        cv[k] <= 1'b0;
        cr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(pop_num)) begin
          cv[k] <= 1'b1;
          cr[k] <= mem[rd_idx[k]];
        end else begin
          cv[k] <= 1'b0;
          cr[k] <= '0;
        end
      end
    end
  end

  assign retireReady_o  = ready;
  assign commitValid0_o = cv[0];
  assign commitValid1_o = cv[1];
  assign commitValid2_o = cv[2];
  assign commitValid3_o = cv[3];
  assign commitReg0_o   = cr[0];
  assign commitReg1_o   = cr[1];
  assign commitReg2_o   = cr[2];
  assign commitReg3_o   = cr[3];
  assign count_o        = count;
  assign overflowErr_o  = overflow_err;

endmodule

// File: tb/tb_retire_release_buffer.sv
// Directed and random stimulus for retire_release_buffer with a tag scoreboard.
// Expected tags are queued when a retire is accepted and compared when released.
// Each step drives inputs mid-cycle and samples outputs 1 time unit after the rising edge.
module tb_retire_release_buffer;
  localparam int TW = 7;
  localparam int D  = 16;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    rv;
  logic [TW-1:0] rr [4];
  logic          hold;
  logic          ready_o;
  logic          cvo [4];
  logic [TW-1:0] cro [4];
  logic [DL:0]   count_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] sb [$];
  logic          merr;

  retire_release_buffer #(.SIZE_PHYSICAL_LOG(TW), .DEPTH(D), .DEPTH_LOG(DL)) dut (
    .clk(clk), .reset(reset),
    .retireValid0_i(rv[0]), .retireValid1_i(rv[1]), .retireValid2_i(rv[2]), .retireValid3_i(rv[3]),
    .retireReg0_i(rr[0]), .retireReg1_i(rr[1]), .retireReg2_i(rr[2]), .retireReg3_i(rr[3]),
    .holdRelease_i(hold), .retireReady_o(ready_o),
    .commitValid0_o(cvo[0]), .commitValid1_o(cvo[1]), .commitValid2_o(cvo[2]), .commitValid3_o(cvo[3]),
    .commitReg0_o(cro[0]), .commitReg1_o(cro[1]), .commitReg2_o(cro[2]), .commitReg3_o(cro[3]),
    .count_o(count_o), .overflowErr_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    reset = 1'b1;
    rv    = v;
    hold  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rv    = 4'b0000;
    sb.delete();
    merr  = 1'b0;
    check("rst_count", 32'(count_o), 0);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_overflow", 32'(err_o), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_commitValid%0d", i), 32'(cvo[i]), 0);
      check($sformatf("rst_commitReg%0d", i), 32'(cro[i]), 0);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                      input logic [TW-1:0] t2, input logic [TW-1:0] t3, input logic h);
    logic [TW-1:0] t   [4];
    logic [TW-1:0] exp [4];
    int   n;
    logic mready;
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    rv   = v;
    hold = h;
    for (int i = 0; i < 4; i++) rr[i] = t[i];
    mready = ((D - sb.size()) >= 4);
    check("ready", 32'(ready_o), 32'(mready));
    n = h ? 0 : ((sb.size() < 4) ? sb.size() : 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) exp[i] = sb.pop_front();
      else       exp[i] = '0;
    end
    if (mready) begin
      for (int i = 0; i < 4; i++) if (v[i]) sb.push_back(t[i]);
    end else if (|v) begin
      merr = 1'b1;
    end
    @(posedge clk);
    #1;
    check("count", 32'(count_o), 32'(sb.size()));
    check("overflow", 32'(err_o), 32'(merr));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("commitValid%0d", i), 32'(cvo[i]), (i < n) ? 1 : 0);
      check($sformatf("commitReg%0d", i), 32'(cro[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    rv    = 4'b0000;
    hold  = 1'b0;
    merr  = 1'b0;
    for (int i = 0; i < 4; i++) rr[i] = '0;
    do_reset(4'b0000);

    // Full 4-wide retire, then release two edges later, then empty.
    step(4'b1111, 7'd5, 7'd6, 7'd7, 7'd8, 1'b0);
    check("req029_count4", 32'(count_o), 4);
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    check("req029_tag0", 32'(cro[0]), 5);
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);

    // Sparse retire: slots 1 and 3 compact into release slots 0 and 1.
    step(4'b1010, 7'd33, 7'd9, 7'd44, 7'd12, 1'b0);
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    check("req030_tag1", 32'(cro[1]), 12);
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);

    // Fill to full under hold (pointers wrap), then offer one more burst.
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, TW'(20 + 4*i), TW'(21 + 4*i), TW'(22 + 4*i), TW'(23 + 4*i), 1'b1);
    end
    check("full_count", 32'(count_o), 16);
    check("full_ready", 32'(ready_o), 0);
    step(4'b1111, 7'd99, 7'd98, 7'd97, 7'd96, 1'b1);
    check("overflow_set", 32'(err_o), 1);

    // Drain from full, then steady 3-in/4-out until occupancy settles at 3.
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(4'b0111, TW'(60 + 3*i), TW'(61 + 3*i), TW'(62 + 3*i), TW'($urandom), 1'b0);
    end
    check("steady_count3", 32'(count_o), 3);
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);

    // Random mix of sparse retires and holds, crossing the wrap point repeatedly.
    for (int i = 0; i < 60; i++) begin
      step(4'($urandom_range(0, 15)), TW'($urandom), TW'($urandom), TW'($urandom), TW'($urandom),
           ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 5; i++) step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);

    // Build count 7 with valid outputs, then reset with a retire pending.
    step(4'b1111, 7'd1, 7'd2, 7'd3, 7'd4, 1'b1);
    step(4'b1111, 7'd11, 7'd12, 7'd13, 7'd14, 1'b1);
    step(4'b0111, 7'd21, 7'd22, 7'd23, 7'd0, 1'b0);
    check("pre_reset_count7", 32'(count_o), 7);
    do_reset(4'b1111);
    step(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
